// File: rtl/gpu_pkg.sv
// Shared definitions for the text-mode GPU command path: opcodes, slot encoding
// and the legal-opcode check.
package gpu_pkg;

  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_MODE = 16'h00C0;
  localparam logic [15:0] OP_PUT  = 16'h00C1;
  localparam logic [15:0] OP_BS   = 16'h00C2;
  localparam logic [15:0] OP_SETY = 16'h00C3;
  localparam logic [15:0] OP_SETX = 16'h00C4;
  localparam logic [15:0] OP_CLS  = 16'h00C5;
  localparam logic [15:0] OP_NL   = 16'h00C6;

  // GPU sampling slot for the current cpuline word: opcode, param, execute
  typedef enum logic [1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_X = 2'd2
  } slot_e;

  function automatic logic is_legal_op(input logic [15:0] op);
    return (op >= OP_MODE) && (op <= OP_NL);
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO of {opcode, param} entries with count, full and empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy, flushed by clr
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_sched.sv
// Buffers CPU commands, filters unknown opcodes and serialises them onto the
// GPU cpuline in A/B/X slots. Define GPU_SCHED_ERR_CNT_EN for the err_cnt port.
module gpu_cmd_sched
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_op,
  input  logic [15:0] cmd_param,
  output logic        cmd_ready,
  output logic [15:0] cpuline,
  output logic        busy,
  output logic        err
`ifdef GPU_SCHED_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  slot_e         slot_r;
  logic [15:0]   cpuline_r;
  logic [15:0]   param_r;
  logic          issued_r;
  logic          err_r;

  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [31:0]   head_s;
  logic          accept_s;
  logic          legal_s;
  logic          push_s;
  logic          pop_s;
  logic [15:0]   load_op_s;

  assign cmd_ready = !full_s;
  assign accept_s  = cmd_valid && !full_s;
  assign legal_s   = is_legal_op(cmd_op);
  assign push_s    = accept_s && legal_s && !clr;
  assign cpuline   = cpuline_r;
  assign err       = err_r;
  assign busy      = (count_s != {CW{1'b0}}) || ((slot_r != SLOT_A) && issued_r);

  // Pop only on the edge that moves into slot A, so opcode and param stay paired
  always_comb begin
    pop_s = 1'b0;
    if (clr) begin
      pop_s = 1'b0;
    end else if ((slot_r == SLOT_X) || ((slot_r == SLOT_B) && !issued_r)) begin
      pop_s = !empty_s;
    end else begin
      pop_s = 1'b0;
    end
    load_op_s = pop_s ? head_s[31:16] : 16'h0000;
  end

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({cmd_op, cmd_param}),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Slot FSM driving the registered cpuline word and the reject pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      slot_r    <= SLOT_A;
      cpuline_r <= 16'h0000;
      param_r   <= 16'h0000;
      issued_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= accept_s && !legal_s && (cmd_op != OP_NOP);
      case (slot_r)
        SLOT_A: begin
          slot_r    <= SLOT_B;
          cpuline_r <= issued_r ? param_r : 16'h0000;
        end
        SLOT_B: begin
          if (issued_r) begin
            slot_r    <= SLOT_X;
            cpuline_r <= 16'h0000;
          end else begin
            slot_r    <= SLOT_A;
            cpuline_r <= load_op_s;
            param_r   <= head_s[15:0];
            issued_r  <= pop_s;
          end
        end
        SLOT_X: begin
          slot_r    <= SLOT_A;
          cpuline_r <= load_op_s;
          param_r   <= head_s[15:0];
          issued_r  <= pop_s;
        end
        default: begin
          slot_r    <= SLOT_A;
          cpuline_r <= 16'h0000;
          issued_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPU_SCHED_ERR_CNT_EN
  logic [7:0] err_cnt_r;
  assign err_cnt = err_cnt_r;

  // Saturating count of reject pulses
  always_ff @(posedge clk) begin
    if (clr) begin
      err_cnt_r <= 8'd0;
    end else if (err_r && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_cmd_sched.sv
// Directed bench for gpu_cmd_sched: per-cycle vector table from reset plus
// hand sequences for the full-FIFO stream and the optional error counter.
module tb_gpu_cmd_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_valid;
  logic [15:0] cmd_op;
  logic [15:0] cmd_param;
  logic        cmd_ready;
  logic [15:0] cpuline;
  logic        busy;
  logic        err;
`ifdef GPU_SCHED_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpu_cmd_sched #(.DEPTH(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_param (cmd_param),
    .cmd_ready (cmd_ready),
    .cpuline   (cpuline),
    .busy      (busy),
    .err       (err)
`ifdef GPU_SCHED_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // One clock cycle: inputs held over the edge, ready sampled before it,
  // cpuline/busy/err sampled after it.
  typedef struct {
    logic        clr;
    logic        valid;
    logic [15:0] op;
    logic [15:0] param;
    logic        ready;
    logic [15:0] line;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic add(input logic c, input logic v, input logic [15:0] op,
                     input logic [15:0] par, input logic rdy,
                     input logic [15:0] line, input logic bsy, input logic e);
    vecs[nv] = '{c, v, op, par, rdy, line, bsy, e};
    nv++;
  endtask

  task automatic idle(input logic [15:0] line, input logic bsy);
    add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, line, bsy, 1'b0);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clr = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [15:0] rx_op [6];
    logic [15:0] rx_par [6];
    int          op_cyc [6];
    int          sent;
    int          got;
    int          cyc;
    logic        acc;
    logic        saw_full;
    logic        want_param;

    clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 16'h0000;
    cmd_param = 16'h0000;

    // reset held, then idle alternation A,B,A,B
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    idle(16'h0000, 1'b0);
    idle(16'h0000, 1'b0);
    idle(16'h0000, 1'b0);
    idle(16'h0000, 1'b0);
    // single command pushed in slot A: opcode two edges later
    add(1'b0, 1'b1, 16'h00C1, 16'h0041, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(16'h00C1, 1'b0);
    idle(16'h0041, 1'b1);
    idle(16'h0000, 1'b1);
    idle(16'h0000, 1'b0);
    idle(16'h0000, 1'b0);
    // back-to-back, first pushed in slot B
    add(1'b0, 1'b1, 16'h00C3, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h00C4, 16'h000A, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(16'h00C3, 1'b1);
    idle(16'h0005, 1'b1);
    idle(16'h0000, 1'b1);
    idle(16'h00C4, 1'b0);
    idle(16'h000A, 1'b1);
    idle(16'h0000, 1'b1);
    idle(16'h0000, 1'b0);
    // illegal opcodes and NOP
    add(1'b0, 1'b1, 16'h00C7, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h1234, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    idle(16'h0000, 1'b0);
    // queue three (push+pop in one cycle), then clr while param in slot B
    add(1'b0, 1'b1, 16'h00C1, 16'h0041, 1'b1, 16'h0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h00C2, 16'h0001, 1'b1, 16'h00C1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h00C5, 16'h0002, 1'b1, 16'h0041, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    idle(16'h0000, 1'b0);
    idle(16'h0000, 1'b0);
    // rejected opcode on the same edge as a pop
    add(1'b0, 1'b1, 16'h00C6, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b1, 16'h00C6, 1'b0, 1'b1);
    idle(16'h0007, 1'b1);
    idle(16'h0000, 1'b1);
    idle(16'h0000, 1'b0);

    reset_dut();
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      clr = vecs[i].clr;
      cmd_valid = vecs[i].valid;
      cmd_op = vecs[i].op;
      cmd_param = vecs[i].param;
      #1;
      chk("cmd_ready", i, {15'd0, cmd_ready}, {15'd0, vecs[i].ready});
      @(posedge clk);
      #1;
      chk("cpuline", i, cpuline, vecs[i].line);
      chk("busy", i, {15'd0, busy}, {15'd0, vecs[i].busy});
      chk("err", i, {15'd0, err}, {15'd0, vecs[i].err});
    end

    // six commands with cmd_valid held: stream in order, 3 cycles apart
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      rx_op[i] = 16'h0000;
      rx_par[i] = 16'h0000;
      op_cyc[i] = 0;
    end
    sent = 0;
    got = 0;
    cyc = 0;
    saw_full = 1'b0;
    want_param = 1'b0;
    while (got < 6 && cyc < 200) begin
      @(negedge clk);
      cmd_valid = (sent < 6);
      cmd_op = 16'h00C0 + 16'(sent);
      cmd_param = 16'h0100 + 16'(sent);
      #1;
      acc = cmd_valid && cmd_ready;
      if (cmd_valid && !cmd_ready) saw_full = 1'b1;
      @(posedge clk);
      if (acc) sent++;
      #1;
      cyc++;
      if (want_param) begin
        rx_par[got] = cpuline;
        got++;
        want_param = 1'b0;
      end else if (cpuline != 16'h0000) begin
        rx_op[got] = cpuline;
        op_cyc[got] = cyc;
        want_param = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    chk("full_ready_low", 0, {15'd0, saw_full}, 16'd1);
    chk("stream_count", 0, 16'(got), 16'd6);
    for (int i = 0; i < 6; i++) begin
      chk("stream_op", i, rx_op[i], 16'h00C0 + 16'(i));
      chk("stream_param", i, rx_par[i], 16'h0100 + 16'(i));
      if (i > 0) chk("stream_gap", i, 16'(op_cyc[i] - op_cyc[i-1]), 16'd3);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("stream_busy_end", 0, {15'd0, busy}, 16'd0);

`ifdef GPU_SCHED_ERR_CNT_EN
    reset_dut();
    cmd_valid = 1'b1;
    cmd_op = 16'h00C7;
    @(negedge clk);
    cmd_op = 16'h1234;
    @(negedge clk);
    cmd_op = 16'h0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_cnt_two", 0, {8'd0, err_cnt}, 16'd2);
    cmd_valid = 1'b1;
    cmd_op = 16'h0BAD;
    repeat (300) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_cnt_sat", 0, {8'd0, err_cnt}, 16'd255);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("err_cnt_clr", 0, {8'd0, err_cnt}, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
